// File: rtl/b11_word_tx.sv
// ---------------------------------------------------------------------------
// b11_word_tx
//
// Transmit-side companion for the b11 scrambler datapath. Words arrive from
// an upstream valid/ready source, are buffered in a small FIFO, and are
// presented one at a time to a b11-style consumer using its active-low
// strobe protocol:
//
//   pop -> SETUP  : tx_word loaded, strobe high (data settles one cycle)
//          STROBE : strobe low for exactly one cycle
//          GAP    : strobe high for GAP cycles so the consumer's
//                   multi-cycle processing completes
//
// Back-to-back words therefore strobe every GAP+2 cycles.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   din         upstream word
//   din_valid   upstream word valid
//   din_ready   FIFO can accept a word (combinational, equals not full)
//   tx_word     word driven to the consumer's x_in (registered)
//   stbo        active-low strobe to the consumer's stbi (registered)
//   busy        high whenever the FSM is not IDLE (registered)
//   fifo_level  current FIFO occupancy, 0..DEPTH (registered)
//   sent_count  words strobed since reset, wraps modulo 2^CNT_W (registered)
//
// Parameters
//   WIDTH  word width
//   DEPTH  FIFO entries, power of two, at least 2
//   GAP    recovery cycles with strobe high after each strobe, at least 1
//   CNT_W  width of the sent-word counter
// ---------------------------------------------------------------------------
module b11_word_tx #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int GAP   = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [WIDTH-1:0]         tx_word,
    output logic                     stbo,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         sent_count
);

    // -----------------------------------------------------------------------
    // Local sizing
    // -----------------------------------------------------------------------
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    // The gap counter only ever holds GAP-1 down to 0.
    localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [GCNT_W-1:0] GAP_LOAD = GCNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP
    } state_t;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    state_t              state;
    state_t              state_d;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [GCNT_W-1:0]   gap_cnt;

    logic                fifo_empty;
    logic                gap_done;
    logic                push;
    logic                pop;

    logic                stbo_d;
    logic                busy_d;

    // -----------------------------------------------------------------------
    // FIFO status and handshake
    //
    // Both empty and full decode from the registered level, so a word pushed
    // on this edge is never seen by this cycle's pop decision, and a slot
    // freed by this cycle's pop is not offered to upstream until next cycle.
    // -----------------------------------------------------------------------
    assign fifo_empty = (fifo_level == '0);
    assign din_ready  = (fifo_level != FULL_LVL);
    assign push       = din_valid && din_ready;
    assign gap_done   = (gap_cnt == '0);

    // The head leaves the FIFO only when the FSM heads into SETUP.
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_GAP) && gap_done));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = fifo_empty ? ST_IDLE : ST_SETUP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic
    //
    // Outputs are decoded from the next state and then registered, so stbo
    // and busy line up with the state they describe without a decode glitch
    // on the consumer's strobe pin.
    // -----------------------------------------------------------------------
    always_comb begin
        stbo_d = (state_d != ST_STROBE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stbo <= 1'b1;
            busy <= 1'b0;
        end else begin
            stbo <= stbo_d;
            busy <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    //
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Transmit word
    //
    // Loaded on the pop edge and held until the next pop; the consumer may
    // still be sampling x_in during the gap, so it is never cleared.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_word <= '0;
        end else if (pop) begin
            tx_word <= mem[rd_ptr];
        end
    end

    // -----------------------------------------------------------------------
    // Gap counter and sent-word counter
    //
    // Both update on the edge that ends the STROBE cycle. The gap counter
    // starts at GAP-1 and the FSM leaves GAP on the cycle it reads zero,
    // giving exactly GAP high cycles after the strobe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt    <= '0;
            sent_count <= '0;
        end else begin
            if (state == ST_STROBE) begin
                gap_cnt    <= GAP_LOAD;
                sent_count <= sent_count + CNT_W'(1);
            end else if ((state == ST_GAP) && !gap_done) begin
                gap_cnt <= gap_cnt - GCNT_W'(1);
            end
        end
    end

endmodule
